sprite_line_fetch: RTL and testbench

SPRITE_LINE_FETCH -- requirements
Module: sprite_line_fetch

---
 rtl/ppu_pkg.sv | 18 +
 rtl/sprite_group_align.sv | 28 ++
 rtl/sprite_line_fetch.sv | 145 ++++++++++++++
 tb/tb_sprite_line_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared sprite-fetch types and constants.
package ppu_pkg;
  typedef enum logic [2:0] {IDLE, EVAL_Y, EVAL_REST, FETCH_LO, FETCH_HI, READY} state_t;
  localparam int SPRITE_SLOTS = 2;
  localparam int ROW_HEIGHT = 8;
  localparam logic [1:0] OAM_Y = 2'd0;
  localparam logic [1:0] OAM_TILE = 2'd1;
  localparam logic [1:0] OAM_ATTR = 2'd2;
  localparam logic [1:0] OAM_X = 2'd3;
  typedef struct packed {
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] x;
    logic [2:0] row;
    logic [7:0] lo;
    logic [7:0] hi;
  } slot_t;
endpackage

// File: rtl/sprite_group_align.sv
// sprite_group_align: extracts one 8-pixel screen group from a sprite row, with optional horizontal flip.
module sprite_group_align
  import ppu_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] group_idx,
  input  logic [7:0] x,
  input  logic       flip,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  output logic [7:0] group_lo,
  output logic [7:0] group_hi
);
  always_comb begin
    group_lo = '0;
    group_hi = '0;
    for (int i = 0; i < 8; i++) begin
      logic [8:0] off;
      logic [2:0] b;
      off = {1'b0, group_idx, 3'(i)} - {1'b0, x};
      b = flip ? off[2:0] : 3'd7 - off[2:0];
      if (valid && off < 9'(ROW_HEIGHT)) begin
        group_lo[i] = lo[b];
        group_hi[i] = hi[b];
      end
    end
  end
endmodule

// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch: per-scanline OAM evaluation and pattern fetch for two sprite slots.
// Define SPRITE_OVERFLOW_EN to scan all 64 entries and flag a third in-range sprite.
module sprite_line_fetch
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [7:0]  scanline,
  input  logic [7:0]  ppu_ctrl1,
  output logic [7:0]  oam_addr,
  input  logic [7:0]  oam_data,
  output logic        vram_req,
  output logic [13:0] vram_addr,
  input  logic        vram_ack,
  input  logic [7:0]  vram_data,
  input  logic        group_req,
  input  logic [4:0]  group_idx,
  output logic [7:0]  sprite_0_pattern_low,
  output logic [7:0]  sprite_0_pattern_high,
  output logic [7:0]  sprite_1_pattern_low,
  output logic [7:0]  sprite_1_pattern_high,
  output logic [7:0]  sprite_0_attr,
  output logic [7:0]  sprite_1_attr,
  output logic        line_ready,
  output logic        sprite_overflow
);
`ifdef SPRITE_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  state_t state;
  logic [5:0] n;
  logic ph, cur, ovf, last, fdone;
  logic [1:0] cnt;
  logic [7:0] scan, row;
  logic [2:0] fr;
  slot_t sl [SPRITE_SLOTS];
  logic [7:0] pat_lo [SPRITE_SLOTS];
  logic [7:0] pat_hi [SPRITE_SLOTS];
  logic [7:0] grp_lo [SPRITE_SLOTS];
  logic [7:0] grp_hi [SPRITE_SLOTS];
  assign row = scan - oam_data;
  assign last = n == 6'd63;
  assign fr = sl[cur].attr[7] ? ~sl[cur].row : sl[cur].row;
  assign fdone = cur || cnt == 2'd1;
  // oam_addr always points one byte ahead of the byte arriving on oam_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {n, ph, cur, cnt, scan, oam_addr, vram_req, vram_addr, line_ready, ovf} <= '0;
      for (int s = 0; s < SPRITE_SLOTS; s++) begin
        sl[s] <= '0;
        pat_lo[s] <= '0;
        pat_hi[s] <= '0;
      end
    end else if (line_start) begin
      state <= EVAL_Y;
      {n, ph, cur, cnt, oam_addr, vram_req, line_ready, ovf} <= '0;
      scan <= scanline;
      for (int s = 0; s < SPRITE_SLOTS; s++) begin
        sl[s] <= '0;
        pat_lo[s] <= '0;
        pat_hi[s] <= '0;
      end
    end else begin
      if (group_req)
        for (int s = 0; s < SPRITE_SLOTS; s++) begin
          pat_lo[s] <= grp_lo[s];
          pat_hi[s] <= grp_hi[s];
        end
      case (state)
        EVAL_Y: begin
          ph <= ~ph;
          if (!ph) oam_addr <= {n, OAM_TILE};
          else if (row < 8'(ROW_HEIGHT) && cnt < 2'(SPRITE_SLOTS)) begin
            sl[cnt[0]].row <= row[2:0];
            oam_addr <= {n, OAM_ATTR};
            state <= EVAL_REST;
          end else begin
            if (row < 8'(ROW_HEIGHT)) ovf <= OVF_EN;
            n <= n + 6'd1;
            oam_addr <= {n + 6'd1, OAM_Y};
            if (last) begin
              state <= cnt != 2'd0 ? FETCH_LO : READY;
              line_ready <= cnt == 2'd0;
            end
          end
        end
        EVAL_REST: begin
          if (oam_addr[1:0] == OAM_ATTR) begin
            sl[cnt[0]].tile <= oam_data;
            oam_addr <= {n, OAM_X};
          end else if (oam_addr[1:0] == OAM_X) begin
            sl[cnt[0]].attr <= oam_data;
            oam_addr <= {n + 6'd1, OAM_Y};
          end else begin
            sl[cnt[0]].x <= oam_data;
            cnt <= cnt + 2'd1;
            n <= n + 6'd1;
            state <= (last || (!OVF_EN && cnt == 2'd1)) ? FETCH_LO : EVAL_Y;
          end
        end
        FETCH_LO, FETCH_HI: begin
          if (!vram_req) begin
            vram_req <= 1'b1;
            vram_addr <= {1'b0, ppu_ctrl1[3], sl[cur].tile, state == FETCH_HI, fr};
          end else if (vram_ack) begin
            vram_req <= 1'b0;
            if (state == FETCH_LO) begin
              sl[cur].lo <= vram_data;
              state <= FETCH_HI;
            end else begin
              sl[cur].hi <= vram_data;
              cur <= 1'b1;
              state <= fdone ? READY : FETCH_LO;
              line_ready <= fdone;
            end
          end
        end
        default: ;
      endcase
    end
  end
  for (genvar g = 0; g < SPRITE_SLOTS; g++) begin : g_align
    sprite_group_align u_align (
      .valid    (line_ready && cnt > 2'(g)),
      .group_idx(group_idx),
      .x        (sl[g].x),
      .flip     (sl[g].attr[6]),
      .lo       (sl[g].lo),
      .hi       (sl[g].hi),
      .group_lo (grp_lo[g]),
      .group_hi (grp_hi[g])
    );
  end
  assign sprite_0_pattern_low = pat_lo[0];
  assign sprite_0_pattern_high = pat_hi[0];
  assign sprite_1_pattern_low = pat_lo[1];
  assign sprite_1_pattern_high = pat_hi[1];
  assign sprite_0_attr = (line_ready && cnt > 2'd0) ? sl[0].attr : '0;
  assign sprite_1_attr = (line_ready && cnt > 2'd1) ? sl[1].attr : '0;
  assign sprite_overflow = ovf;
endmodule

// File: tb/tb_sprite_line_fetch.sv
// tb_sprite_line_fetch: randomized and directed checks against a scanline-level sprite model.
module tb_sprite_line_fetch;
  logic clk = 0, rst_n = 0, line_start = 0, vram_ack = 0, group_req = 0;
  logic [7:0] scanline = 0, ppu_ctrl1 = 0, oam_data, vram_data = 0;
  logic [4:0] group_idx = 0;
  logic [7:0] oam_addr;
  logic vram_req;
  logic [13:0] vram_addr;
  logic [7:0] s0l, s0h, s1l, s1h, s0a, s1a;
  logic line_ready, sprite_overflow;
  logic [7:0] oam [256];
  logic [7:0] vmem [16384];
  logic [13:0] acked [$];
  int ack_delay = 0;
  int n_chk = 0, n_pass = 0;
  logic [7:0] m_lo [2], m_hi [2], m_attr [2], m_x [2];
  int m_n;
  bit m_ovf;
  logic [13:0] m_addr [$];
`ifdef SPRITE_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  sprite_line_fetch dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .scanline(scanline),
    .ppu_ctrl1(ppu_ctrl1), .oam_addr(oam_addr), .oam_data(oam_data),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack), .vram_data(vram_data),
    .group_req(group_req), .group_idx(group_idx),
    .sprite_0_pattern_low(s0l), .sprite_0_pattern_high(s0h),
    .sprite_1_pattern_low(s1l), .sprite_1_pattern_high(s1h),
    .sprite_0_attr(s0a), .sprite_1_attr(s1a),
    .line_ready(line_ready), .sprite_overflow(sprite_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) oam_data <= oam[oam_addr];

  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (vram_ack) begin
        vram_ack = 0;
        cnt = 0;
      end else if (vram_req) begin
        if (cnt >= ack_delay) begin
          vram_ack = 1;
          vram_data = vmem[vram_addr];
          acked.push_back(vram_addr);
        end else cnt++;
      end else cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model(input logic [7:0] scan, input logic [7:0] ctrl);
    int hits = 0;
    m_n = 0;
    m_ovf = 0;
    m_addr.delete();
    for (int s = 0; s < 2; s++) {m_lo[s], m_hi[s], m_attr[s], m_x[s]} = '0;
    for (int e = 0; e < 64; e++) begin
      int row, r, a;
      row = int'(scan) - int'(oam[4*e]);
      if (row < 0) row += 256;
      if (row < 8) begin
        hits++;
        if (m_n < 2) begin
          r = oam[4*e+2][7] ? 7 - row : row;
          a = ctrl[3] * 4096 + oam[4*e+1] * 16 + r;
          m_addr.push_back(14'(a));
          m_addr.push_back(14'(a + 8));
          m_lo[m_n] = vmem[a];
          m_hi[m_n] = vmem[a + 8];
          m_attr[m_n] = oam[4*e+2];
          m_x[m_n] = oam[4*e+3];
          m_n++;
        end
      end
    end
    m_ovf = OVF && hits > 2;
  endtask

  function automatic logic [7:0] exp_group(input logic [7:0] pat, input logic [7:0] x,
                                           input logic [7:0] attr, input int g);
    logic [7:0] res = '0;
    for (int i = 0; i < 8; i++) begin
      int off;
      off = g * 8 + i - int'(x);
      if (off >= 0 && off < 8) res[i] = attr[6] ? pat[off] : pat[7-off];
    end
    return res;
  endfunction

  task automatic fill_miss(input logic [7:0] scan);
    for (int e = 0; e < 64; e++) begin
      oam[4*e] = 8'(scan + 8 + $urandom_range(0, 239));
      oam[4*e+1] = 8'($urandom);
      oam[4*e+2] = 8'($urandom);
      oam[4*e+3] = 8'($urandom);
    end
  endtask

  task automatic put(input int e, input logic [7:0] y, input logic [7:0] t,
                     input logic [7:0] a, input logic [7:0] x);
    oam[4*e] = y;
    oam[4*e+1] = t;
    oam[4*e+2] = a;
    oam[4*e+3] = x;
  endtask

  task automatic start_line(input logic [7:0] scan, input logic [7:0] ctrl);
    @(negedge clk);
    scanline = scan;
    ppu_ctrl1 = ctrl;
    line_start = 1;
    @(negedge clk);
    line_start = 0;
    acked.delete();
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!line_ready && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("line_ready", line_ready, 1);
  endtask

  task automatic verify_line();
    check("n_fetch", acked.size(), m_addr.size());
    for (int i = 0; i < acked.size() && i < m_addr.size(); i++) check("vram_addr", acked[i], m_addr[i]);
    check("overflow", sprite_overflow, m_ovf);
    check("attr0", s0a, m_n > 0 ? m_attr[0] : 8'h00);
    check("attr1", s1a, m_n > 1 ? m_attr[1] : 8'h00);
  endtask

  task automatic group_check(input int g);
    @(negedge clk);
    group_req = 1;
    group_idx = 5'(g);
    @(negedge clk);
    group_req = 0;
    check("s0_lo", s0l, m_n > 0 ? exp_group(m_lo[0], m_x[0], m_attr[0], g) : 8'h00);
    check("s0_hi", s0h, m_n > 0 ? exp_group(m_hi[0], m_x[0], m_attr[0], g) : 8'h00);
    check("s1_lo", s1l, m_n > 1 ? exp_group(m_lo[1], m_x[1], m_attr[1], g) : 8'h00);
    check("s1_hi", s1h, m_n > 1 ? exp_group(m_hi[1], m_x[1], m_attr[1], g) : 8'h00);
  endtask

  task automatic line(input logic [7:0] scan, input logic [7:0] ctrl);
    int cyc;
    start_line(scan, ctrl);
    wait_ready(cyc);
    model(scan, ctrl);
    verify_line();
  endtask

  initial begin
    int cyc, k, nh;
    logic [13:0] a0;
    logic [7:0] scan, ctrl;
    foreach (vmem[i]) vmem[i] = 8'($urandom);
    fill_miss(0);
    repeat (3) @(negedge clk);
    check("rst_oam_addr", oam_addr, 0);
    check("rst_vram_req", vram_req, 0);
    check("rst_vram_addr", vram_addr, 0);
    check("rst_ready", line_ready, 0);
    check("rst_ovf", sprite_overflow, 0);
    check("rst_pat", {s0l, s0h, s1l, s1h, s0a, s1a} == 0, 1);
    rst_n = 1;

    fill_miss(13);
    put(5, 8'd10, 8'h21, 8'h00, 8'h14);
    vmem[14'h213] = 8'h80;
    line(13, 8'h00);
    check("d_addr_lo", acked.size() > 0 ? acked[0] : 14'h0, 14'h0213);
    check("d_addr_hi", acked.size() > 1 ? acked[1] : 14'h0, 14'h021B);
    group_check(2);
    check("d_grp2", s0l, 8'h10);

    put(5, 8'd10, 8'h21, 8'h40, 8'h14);
    vmem[14'h213] = 8'h08;
    line(13, 8'h00);
    group_check(2);
    check("hflip_grp2", s0l, 8'h80);
    group_check(3);

    put(5, 8'd10, 8'h21, 8'h80, 8'h14);
    line(13, 8'h00);
    check("vflip_addr", acked.size() > 0 ? acked[0] : 14'h0, 14'h0214);
    group_check(2);

    fill_miss(50);
    put(1, 8'd48, 8'h10, 8'h01, 8'h20);
    put(2, 8'd45, 8'h11, 8'h02, 8'h24);
    put(3, 8'd50, 8'h12, 8'h03, 8'h28);
    line(50, 8'h08);
    check("ovf_third", sprite_overflow, OVF);
    check("slot0_entry1", s0a, 8'h01);
    check("slot1_entry2", s1a, 8'h02);
    group_check(4);
    group_check(5);

    ack_delay = 7;
    fill_miss(100);
    put(9, 8'd96, 8'h5A, 8'h00, 8'h33);
    start_line(100, 8'h08);
    k = 0;
    while (!vram_req && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("req_seen", vram_req, 1);
    a0 = vram_addr;
    repeat (7) begin
      @(negedge clk);
      check("req_hold", {vram_req, vram_addr}, {1'b1, a0});
    end
    wait_ready(cyc);
    model(100, 8'h08);
    verify_line();
    group_check(6);
    group_check(7);
    ack_delay = 0;

    ack_delay = 3;
    fill_miss(120);
    put(0, 8'd118, 8'h44, 8'h05, 8'h10);
    put(7, 8'd115, 8'h45, 8'h06, 8'h18);
    start_line(120, 8'h00);
    k = 0;
    while (!(acked.size() >= 1 && vram_req && !vram_ack) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("in_fetch_hi", acked.size() == 1 && vram_req, 1);
    fill_miss(120);
    start_line(120, 8'h00);
    check("abort_ready", line_ready, 0);
    check("abort_attr", {s0a, s1a}, 0);
    check("abort_pat", {s0l, s0h, s1l, s1h}, 0);
    wait_ready(cyc);
    model(120, 8'h00);
    verify_line();
    group_check(2);
    group_check(3);
    ack_delay = 0;

    fill_miss(30);
    put(0, 8'd30, 8'h77, 8'hC0, 8'h40);
    start_line(30, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rest_addr_busy", oam_addr != 0, 1);
    rst_n = 0;
    #1;
    check("arst_oam_addr", oam_addr, 0);
    check("arst_vram_req", vram_req, 0);
    check("arst_ready", line_ready, 0);
    check("arst_out", {s0l, s0h, s1l, s1h, s0a, s1a, sprite_overflow} == 0, 1);
    @(negedge clk);
    rst_n = 1;

    fill_miss(77);
    start_line(77, 8'h00);
    wait_ready(cyc);
    check("empty_within_129", cyc <= 129, 1);
    model(77, 8'h00);
    verify_line();
    group_check($urandom_range(0, 31));

    repeat (20) begin
      scan = 8'($urandom);
      ctrl = 8'($urandom);
      ack_delay = $urandom_range(0, 3);
      fill_miss(scan);
      nh = $urandom_range(0, 3);
      repeat (nh) put($urandom_range(0, 63), 8'(scan - $urandom_range(0, 7)),
                      8'($urandom), 8'($urandom), 8'($urandom));
      line(scan, ctrl);
      group_check(m_n > 0 ? int'(m_x[0] >> 3) : $urandom_range(0, 31));
      group_check(m_n > 0 ? (int'(m_x[0] >> 3) + 1) % 32 : $urandom_range(0, 31));
      group_check(m_n > 1 ? int'(m_x[1] >> 3) : $urandom_range(0, 31));
    end
    ack_delay = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
